multi_master_arbiter: RTL and testbench
=======================================

// Module: multi_master_arbiter
// PURPOSE
//  N-master to single-slave bridge on the req/ack/resp bus (cmd=1 write, cmd=0 read).
//  Arbitrates in round-robin or fixed-priority mode and forwards one transaction at a time.
//  Routes ack/resp/rdata back to the granted master only.
//  A response watchdog returns an error response if the slave stalls.
//  Sits between the master cluster and a shared memory/peripheral slave.
// PARAMETERS
//  N_MASTERS   4   number of masters, 2..16
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  ARB_MODE    0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  TIMEOUT     256 cycles to wait for s_ack/s_resp; 0 disables the watchdog
// PORTS
//  clk_i      in   1             clock, rising edge
//  rst_i      in   1             reset, asynchronous, active-high
//  m_req_i    in   N             per-master request, held until the master is released
//  m_cmd_i    in   N             per-master cmd, 1 = write
//  m_addr_i   in   N*ADDR_W      packed; master k at [k*ADDR_W +: ADDR_W]
//  m_wdata_i  in   N*DATA_W      packed write data
//  m_ack_o    out  N             one-cycle accept pulse to the granted master
//  m_resp_o   out  N             one-cycle read-response pulse
//  m_err_o    out  N             qualifies m_resp_o/m_ack_o; 1 = timeout
//  m_rdata_o  out  N*DATA_W      registered read data, holds its last value
//  s_req_o    out  1             request to the slave
//  s_cmd_o    out  1             slave-side cmd
//  s_addr_o   out  ADDR_W        slave-side address
//  s_wdata_o  out  DATA_W        slave-side write data
//  s_ack_i    in   1             slave accepted the request
//  s_resp_i   in   1             slave read data valid
//  s_rdata_i  in   DATA_W        slave read data
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, rr_last=N-1 so master 0 wins first, watchdog=0. Applies immediately, mid-transaction included.
//  FSM IDLE->REQ->(WAIT_RESP)->RELEASE->IDLE; all outputs registered.
//  IDLE: any m_req -> pick winner g and latch g. Latch s_addr/s_cmd, and s_wdata only when cmd=1. Set s_req=1 -> REQ.
//    m_req seen at edge k gives s_req high from edge k.
//    RR: first requester after rr_last, cyclically. rr_last<=g at grant. FP: lowest index.
//  REQ: s_ack -> s_req<=0, m_ack[g] pulse.
//    Write -> RELEASE. Read -> WAIT_RESP.
//    Read with s_ack and s_resp in the same cycle: both pulses in the same cycle, then -> RELEASE.
//  WAIT_RESP: s_resp -> m_resp[g] pulse, m_rdata[g]<=s_rdata -> RELEASE.
//  RELEASE: wait for m_req[g]==0, then -> IDLE. The next grant is no earlier than 1 cycle after the drop.
//  s_ack/s_resp outside the expected state: ignored. s_resp on a write: ignored.
//  Watchdog: cleared on entry to REQ and WAIT_RESP, counts each cycle in those states.
//    Reaching TIMEOUT-1 with no event, in REQ: s_req<=0, m_ack[g] with m_err[g]=1.
//      Write -> RELEASE. Read -> also m_resp[g] in the same cycle, rdata<=0.
//    Reaching TIMEOUT-1 with no event, in WAIT_RESP: m_resp[g] with m_err[g]=1, m_rdata[g]<=0 -> RELEASE.
//    Slave event on the expiry cycle: the event wins, no error.
//  m_err is 0 whenever m_ack/m_resp is 0. Non-granted masters see no pulses and no rdata change.
//  Changes to the granted master's inputs after grant are ignored; slave outputs stay latched.
// STRUCTURE
//  arbiter_pkg: state_t enum {IDLE,REQ,WAIT_RESP,RELEASE}, ARB_RR/ARB_FP constants, idx width function.
//  Sub-module rr_pick: combinational N-way picker (req vector, last index, mode) -> one-hot + index.
// TESTING
//  1 Single write: m1 req, addr=0x10, wdata=0xA5 -> s_req next cycle with those values.
//    s_ack -> m_ack[1] pulse, m_err=0. m1 drops req -> IDLE.
//  2 Single read: m2 reads 0x20; slave acks, then s_resp 3 cycles later with 0xDEAD.
//    -> m_resp[2] pulse, m_rdata[2]=0xDEAD; other m_rdata unchanged.
//  3 RR fairness: all 4 hold req, back-to-back writes -> grant order 0,1,2,3,0.
//    ARB_MODE=1 -> grant order 0,0,0 while m0 keeps re-requesting.
//  4 Timeout: TIMEOUT=8, read with s_ack but no s_resp -> m_resp+m_err on the 8th WAIT_RESP cycle, rdata=0.
//    Write with no ack -> m_ack+m_err, s_req drops.
//  5 Same-cycle s_ack+s_resp on a read -> m_ack and m_resp together, rdata captured.
//  6 rst_i pulsed while in WAIT_RESP -> all outputs 0 within the same cycle.
//    The next simultaneous request from m0 and m3 grants m0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared types and helpers for the multi-master bridge.
// FSM encoding, arbitration mode constants, index width helper.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    RELEASE
  } state_t;

  localparam int ARB_RR = 0;
  localparam int ARB_FP = 1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_master_arbiter_rr_pick.sv
// rr_pick: combinational N-way requester picker.
// Scans cyclically after last_i; fixed mode always scans from index 0.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          mode_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int   w_start;
  int   w_cand;
  logic w_found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    w_start  = mode_i ? (N - 1) : int'(last_i);
    for (int k = 1; k <= N; k++) begin
      w_cand = (w_start + k) % N;
      if (!w_found && req_i[w_cand]) begin
        w_found          = 1'b1;
        idx_o            = IW'(w_cand);
        onehot_o[w_cand] = 1'b1;
      end
    end
    valid_o = w_found;
  end

endmodule

// File: rtl/multi_master_arbiter.sv
// multi_master_arbiter: N-master to single-slave req/ack/resp bridge
// with round-robin or fixed-priority arbitration and a response watchdog.
module multi_master_arbiter
  import arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_MASTERS-1:0]          m_req_i,
  input  logic [N_MASTERS-1:0]          m_cmd_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_resp_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic                          s_req_o,
  output logic                          s_cmd_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_ack_i,
  input  logic                          s_resp_i,
  input  logic [DATA_W-1:0]             s_rdata_i
);

  localparam int          IW      = idx_w(N_MASTERS);
  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t                      r_state, w_state;
  logic [IW-1:0]               r_gnt, w_gnt;
  logic [IW-1:0]               r_rr_last, w_rr_last;
  logic [31:0]                 r_wd, w_wd;
  logic                        r_s_req, w_s_req;
  logic                        r_s_cmd, w_s_cmd;
  logic [ADDR_W-1:0]           r_s_addr, w_s_addr;
  logic [DATA_W-1:0]           r_s_wdata, w_s_wdata;
  logic [N_MASTERS-1:0]        r_m_ack, w_m_ack;
  logic [N_MASTERS-1:0]        r_m_resp, w_m_resp;
  logic [N_MASTERS-1:0]        r_m_err, w_m_err;
  logic [N_MASTERS*DATA_W-1:0] r_m_rdata, w_m_rdata;

  logic [N_MASTERS-1:0] w_pick_oh;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_vld;
  logic                 w_expired;

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i    (m_req_i),
    .last_i   (r_rr_last),
    .mode_i   (ARB_MODE == ARB_FP),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx),
    .valid_o  (w_pick_vld)
  );

  assign w_expired = WD_EN && (r_wd == WD_LAST);

  always_comb begin
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_rr_last = r_rr_last;
    w_wd      = r_wd;
    w_s_req   = r_s_req;
    w_s_cmd   = r_s_cmd;
    w_s_addr  = r_s_addr;
    w_s_wdata = r_s_wdata;
    w_m_ack   = '0;
    w_m_resp  = '0;
    w_m_err   = '0;
    w_m_rdata = r_m_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt     = w_pick_idx;
          w_rr_last = w_pick_idx;
          w_s_cmd   = |(m_cmd_i & w_pick_oh);
          w_s_addr  = m_addr_i[int'(w_pick_idx)*ADDR_W +: ADDR_W];
          if (w_s_cmd)
            w_s_wdata = m_wdata_i[int'(w_pick_idx)*DATA_W +: DATA_W];
          w_s_req   = 1'b1;
          w_wd      = '0;
          w_state   = REQ;
        end
      end
      REQ: begin
        w_wd = r_wd + 32'd1;
        if (s_ack_i) begin
          w_s_req        = 1'b0;
          w_m_ack[r_gnt] = 1'b1;
          if (r_s_cmd) begin
            w_state = RELEASE;
          end else if (s_resp_i) begin
            w_m_resp[r_gnt] = 1'b1;
            w_m_rdata[int'(r_gnt)*DATA_W +: DATA_W] = s_rdata_i;
            w_state = RELEASE;
          end else begin
            w_wd    = '0;
            w_state = WAIT_RESP;
          end
        end else if (w_expired) begin
          // stalled slave: error-ack, and error-resp for reads
          w_s_req        = 1'b0;
          w_m_ack[r_gnt] = 1'b1;
          w_m_err[r_gnt] = 1'b1;
          if (!r_s_cmd) begin
            w_m_resp[r_gnt] = 1'b1;
            w_m_rdata[int'(r_gnt)*DATA_W +: DATA_W] = '0;
          end
          w_state = RELEASE;
        end
      end
      WAIT_RESP: begin
        w_wd = r_wd + 32'd1;
        if (s_resp_i) begin
          w_m_resp[r_gnt] = 1'b1;
          w_m_rdata[int'(r_gnt)*DATA_W +: DATA_W] = s_rdata_i;
          w_state = RELEASE;
        end else if (w_expired) begin
          w_m_resp[r_gnt] = 1'b1;
          w_m_err[r_gnt]  = 1'b1;
          w_m_rdata[int'(r_gnt)*DATA_W +: DATA_W] = '0;
          w_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!m_req_i[r_gnt])
          w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rr_last <= IW'(N_MASTERS - 1);
      r_wd      <= '0;
      r_s_req   <= 1'b0;
      r_s_cmd   <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_ack   <= '0;
      r_m_resp  <= '0;
      r_m_err   <= '0;
      r_m_rdata <= '0;
    end else begin
      r_state   <= w_state;
      r_gnt     <= w_gnt;
      r_rr_last <= w_rr_last;
      r_wd      <= w_wd;
      r_s_req   <= w_s_req;
      r_s_cmd   <= w_s_cmd;
      r_s_addr  <= w_s_addr;
      r_s_wdata <= w_s_wdata;
      r_m_ack   <= w_m_ack;
      r_m_resp  <= w_m_resp;
      r_m_err   <= w_m_err;
      r_m_rdata <= w_m_rdata;
    end
  end

  assign m_ack_o   = r_m_ack;
  assign m_resp_o  = r_m_resp;
  assign m_err_o   = r_m_err;
  assign m_rdata_o = r_m_rdata;
  assign s_req_o   = r_s_req;
  assign s_cmd_o   = r_s_cmd;
  assign s_addr_o  = r_s_addr;
  assign s_wdata_o = r_s_wdata;

endmodule

// File: tb/tb_multi_master_arbiter.sv
// tb_multi_master_arbiter: directed bench for the bridge, RR and FP instances,
// with a transaction-level reference model compared every cycle.
module tb_multi_master_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   m_req [2];
  logic [3:0]   m_cmd [2];
  logic [127:0] m_addr [2];
  logic [127:0] m_wdata [2];
  logic [3:0]   m_ack [2];
  logic [3:0]   m_resp [2];
  logic [3:0]   m_err [2];
  logic [127:0] m_rdata [2];
  logic         s_req [2];
  logic         s_cmd [2];
  logic [31:0]  s_addr [2];
  logic [31:0]  s_wdata [2];
  logic         s_ack [2];
  logic         s_resp [2];
  logic [31:0]  s_rdata [2];

  multi_master_arbiter #(
    .N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(TO)
  ) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req[0]), .m_cmd_i(m_cmd[0]),
    .m_addr_i(m_addr[0]), .m_wdata_i(m_wdata[0]),
    .m_ack_o(m_ack[0]), .m_resp_o(m_resp[0]),
    .m_err_o(m_err[0]), .m_rdata_o(m_rdata[0]),
    .s_req_o(s_req[0]), .s_cmd_o(s_cmd[0]),
    .s_addr_o(s_addr[0]), .s_wdata_o(s_wdata[0]),
    .s_ack_i(s_ack[0]), .s_resp_i(s_resp[0]), .s_rdata_i(s_rdata[0])
  );

  multi_master_arbiter #(
    .N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(TO)
  ) u_fp (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req[1]), .m_cmd_i(m_cmd[1]),
    .m_addr_i(m_addr[1]), .m_wdata_i(m_wdata[1]),
    .m_ack_o(m_ack[1]), .m_resp_o(m_resp[1]),
    .m_err_o(m_err[1]), .m_rdata_o(m_rdata[1]),
    .s_req_o(s_req[1]), .s_cmd_o(s_cmd[1]),
    .s_addr_o(s_addr[1]), .s_wdata_o(s_wdata[1]),
    .s_ack_i(s_ack[1]), .s_resp_i(s_resp[1]), .s_rdata_i(s_rdata[1])
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 free, 1 awaiting accept,
  // 2 awaiting data, 3 awaiting the owner's request drop.
  int           ph [2];
  int           g [2];
  int           last [2];
  int           waited [2];
  logic         e_sreq [2];
  logic         e_scmd [2];
  logic [31:0]  e_saddr [2];
  logic [31:0]  e_swdata [2];
  logic [3:0]   e_ack [2];
  logic [3:0]   e_resp [2];
  logic [3:0]   e_err [2];
  logic [127:0] e_rd [2];

  task automatic model_step(input int d);
    int w;
    int base;
    int c;
    if (rst) begin
      ph[d] = 0; g[d] = 0; last[d] = 3; waited[d] = 0;
      e_sreq[d] = 1'b0; e_scmd[d] = 1'b0;
      e_saddr[d] = '0; e_swdata[d] = '0;
      e_ack[d] = '0; e_resp[d] = '0; e_err[d] = '0; e_rd[d] = '0;
      return;
    end
    e_ack[d] = '0; e_resp[d] = '0; e_err[d] = '0;
    case (ph[d])
      0: if (m_req[d] != 4'b0) begin
        base = (d == 1) ? 3 : last[d];
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          c = (base + k) % 4;
          if (w < 0 && m_req[d][c]) w = c;
        end
        g[d] = w; last[d] = w;
        e_sreq[d] = 1'b1;
        e_scmd[d] = m_cmd[d][w];
        e_saddr[d] = m_addr[d][w*32 +: 32];
        if (m_cmd[d][w]) e_swdata[d] = m_wdata[d][w*32 +: 32];
        waited[d] = 0; ph[d] = 1;
      end
      1: begin
        waited[d]++;
        if (s_ack[d]) begin
          e_sreq[d] = 1'b0; e_ack[d][g[d]] = 1'b1;
          if (e_scmd[d]) ph[d] = 3;
          else if (s_resp[d]) begin
            e_resp[d][g[d]] = 1'b1;
            e_rd[d][g[d]*32 +: 32] = s_rdata[d];
            ph[d] = 3;
          end else begin
            ph[d] = 2; waited[d] = 0;
          end
        end else if (waited[d] == TO) begin
          e_sreq[d] = 1'b0;
          e_ack[d][g[d]] = 1'b1; e_err[d][g[d]] = 1'b1;
          if (!e_scmd[d]) begin
            e_resp[d][g[d]] = 1'b1;
            e_rd[d][g[d]*32 +: 32] = '0;
          end
          ph[d] = 3;
        end
      end
      2: begin
        waited[d]++;
        if (s_resp[d]) begin
          e_resp[d][g[d]] = 1'b1;
          e_rd[d][g[d]*32 +: 32] = s_rdata[d];
          ph[d] = 3;
        end else if (waited[d] == TO) begin
          e_resp[d][g[d]] = 1'b1; e_err[d][g[d]] = 1'b1;
          e_rd[d][g[d]*32 +: 32] = '0;
          ph[d] = 3;
        end
      end
      default: if (!m_req[d][g[d]]) ph[d] = 0;
    endcase
  endtask

  always @(posedge clk or posedge rst)
    for (int d = 0; d < 2; d++) model_step(d);

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d s_req", d), 128'(s_req[d]), 128'(e_sreq[d]));
      chk($sformatf("d%0d s_cmd", d), 128'(s_cmd[d]), 128'(e_scmd[d]));
      chk($sformatf("d%0d s_addr", d), 128'(s_addr[d]), 128'(e_saddr[d]));
      chk($sformatf("d%0d s_wdata", d), 128'(s_wdata[d]), 128'(e_swdata[d]));
      chk($sformatf("d%0d m_ack", d), 128'(m_ack[d]), 128'(e_ack[d]));
      chk($sformatf("d%0d m_resp", d), 128'(m_resp[d]), 128'(e_resp[d]));
      chk($sformatf("d%0d m_err", d), 128'(m_err[d]), 128'(e_err[d]));
      chk($sformatf("d%0d m_rdata", d), m_rdata[d], e_rd[d]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic serve(input int d, output int who);
    int n;
    n = 0;
    while (!s_req[d] && n < 20) begin
      tick(1);
      n++;
    end
    chk($sformatf("d%0d s_req wait", d), 128'(s_req[d]), 128'(1'b1));
    s_ack[d] = 1'b1;
    tick(1);
    s_ack[d] = 1'b0;
    who = oh2i(m_ack[d]);
  endtask

  task automatic read_now(input int k, input logic [31:0] a,
                          input logic [31:0] dat);
    m_cmd[0][k] = 1'b0;
    m_addr[0][k*32 +: 32] = a;
    m_req[0][k] = 1'b1;
    tick(1);
    s_ack[0] = 1'b1; s_resp[0] = 1'b1; s_rdata[0] = dat;
    tick(1);
    s_ack[0] = 1'b0; s_resp[0] = 1'b0;
    chk("same-cycle m_ack", 128'(m_ack[0]), 128'(1) << k);
    chk("same-cycle m_resp", 128'(m_resp[0]), 128'(1) << k);
    chk("same-cycle m_err", 128'(m_err[0]), 128'(0));
    chk("same-cycle rdata", 128'(m_rdata[0][k*32 +: 32]), 128'(dat));
    m_req[0][k] = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};
  int who;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_req[d] = '0; m_cmd[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
      s_ack[d] = 1'b0; s_resp[d] = 1'b0; s_rdata[d] = '0;
    end
    tick(1);
    chk("reset s_req", 128'(s_req[0]), 128'(0));
    chk("reset m_ack", 128'(m_ack[0]), 128'(0));
    chk("reset m_rdata", m_rdata[0], 128'(0));
    rst = 1'b0;
    tick(1);

    // single write from m1
    m_cmd[0] = 4'b0010;
    m_addr[0][63:32] = 32'h10;
    m_wdata[0][63:32] = 32'hA5;
    m_req[0] = 4'b0010;
    tick(1);
    chk("t1 s_req", 128'(s_req[0]), 128'(1));
    chk("t1 s_cmd", 128'(s_cmd[0]), 128'(1));
    chk("t1 s_addr", 128'(s_addr[0]), 128'(32'h10));
    chk("t1 s_wdata", 128'(s_wdata[0]), 128'(32'hA5));
    s_ack[0] = 1'b1;
    tick(1);
    s_ack[0] = 1'b0;
    chk("t1 m_ack", 128'(m_ack[0]), 128'(4'b0010));
    chk("t1 m_err", 128'(m_err[0]), 128'(0));
    chk("t1 s_req drop", 128'(s_req[0]), 128'(0));
    m_req[0] = '0;
    tick(2);

    // single read from m2, data three cycles after the accept
    m_cmd[0] = 4'b0000;
    m_addr[0][95:64] = 32'h20;
    m_req[0] = 4'b0100;
    tick(1);
    chk("t2 s_addr", 128'(s_addr[0]), 128'(32'h20));
    chk("t2 s_wdata held", 128'(s_wdata[0]), 128'(32'hA5));
    s_ack[0] = 1'b1;
    tick(1);
    s_ack[0] = 1'b0;
    chk("t2 m_ack", 128'(m_ack[0]), 128'(4'b0100));
    chk("t2 no early resp", 128'(m_resp[0]), 128'(0));
    tick(2);
    s_resp[0] = 1'b1; s_rdata[0] = 32'hDEAD;
    tick(1);
    s_resp[0] = 1'b0;
    chk("t2 m_resp", 128'(m_resp[0]), 128'(4'b0100));
    chk("t2 rdata m2", 128'(m_rdata[0][95:64]), 128'(32'hDEAD));
    chk("t2 rdata m1", 128'(m_rdata[0][63:32]), 128'(0));
    m_req[0] = '0;
    tick(2);
    do_reset();

    // round-robin fairness
    m_cmd[0] = 4'hF;
    m_req[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serve(0, who);
      chk($sformatf("rr grant %0d", i), 128'(who), 128'(exp_rr[i]));
      if (who >= 0) begin
        m_req[0][who] = 1'b0;
        tick(1);
        m_req[0][who] = 1'b1;
      end else tick(1);
    end
    m_req[0] = '0;
    tick(2);

    // fixed priority: m0 keeps winning
    m_cmd[1] = 4'hF;
    m_req[1] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      serve(1, who);
      chk($sformatf("fp grant %0d", i), 128'(who), 128'(0));
      if (who >= 0) begin
        m_req[1][who] = 1'b0;
        tick(1);
        m_req[1][who] = 1'b1;
      end else tick(1);
    end
    m_req[1] = '0;
    tick(2);

    read_now(0, 32'h40, 32'h1234_5678);

    // read watchdog after accept
    m_cmd[0] = 4'b0000;
    m_req[0] = 4'b0001;
    tick(1);
    s_ack[0] = 1'b1;
    tick(1);
    s_ack[0] = 1'b0;
    tick(7);
    chk("t4 resp before expiry", 128'(m_resp[0]), 128'(0));
    tick(1);
    chk("t4 timeout m_resp", 128'(m_resp[0]), 128'(4'b0001));
    chk("t4 timeout m_err", 128'(m_err[0]), 128'(4'b0001));
    chk("t4 timeout rdata", 128'(m_rdata[0][31:0]), 128'(0));
    m_req[0] = '0;
    tick(2);

    // write watchdog, never accepted
    m_cmd[0] = 4'b1000;
    m_addr[0][127:96] = 32'h30;
    m_wdata[0][127:96] = 32'h77;
    m_req[0] = 4'b1000;
    tick(1);
    tick(7);
    chk("t4w s_req held", 128'(s_req[0]), 128'(1));
    tick(1);
    chk("t4w m_ack", 128'(m_ack[0]), 128'(4'b1000));
    chk("t4w m_err", 128'(m_err[0]), 128'(4'b1000));
    chk("t4w s_req drop", 128'(s_req[0]), 128'(0));
    m_req[0] = '0;
    tick(2);

    // reset while waiting for read data
    read_now(2, 32'h60, 32'hCAFE);
    m_cmd[0] = 4'b0000;
    m_addr[0][63:32] = 32'h50;
    m_req[0] = 4'b0010;
    tick(1);
    s_ack[0] = 1'b1;
    tick(1);
    s_ack[0] = 1'b0;
    tick(2);
    #1 rst = 1'b1;
    #1;
    chk("t6 s_req", 128'(s_req[0]), 128'(0));
    chk("t6 s_addr", 128'(s_addr[0]), 128'(0));
    chk("t6 m_ack", 128'(m_ack[0]), 128'(0));
    chk("t6 m_resp", 128'(m_resp[0]), 128'(0));
    chk("t6 m_rdata", m_rdata[0], 128'(0));
    m_req[0] = '0;
    tick(1);
    rst = 1'b0;
    m_cmd[0] = 4'b1001;
    m_addr[0][31:0] = 32'hA0;
    m_addr[0][127:96] = 32'hB0;
    m_req[0] = 4'b1001;
    tick(1);
    chk("t6 s_addr m0", 128'(s_addr[0]), 128'(32'hA0));
    serve(0, who);
    chk("t6 grant", 128'(who), 128'(0));
    m_req[0] = '0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
